// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes and frame width.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input int mode);
    case (mode)
      PARITY_EVEN: return ^data;
      PARITY_ODD:  return ~^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO; read data is registered and valid the cycle after a pop.
// Writes when full and pops when empty are ignored; o_full/o_empty are the only backpressure.
`timescale 1ns/1ps
module fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_dat;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr  = i_wr_en && !o_full;
  assign w_do_rd  = i_rd_en && !o_empty;
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_rd_dat = r_rd_dat;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rd_dat <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) begin
        r_rd_dat <= r_mem[r_rptr];
        r_rptr   <= r_rptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Drains a byte FIFO onto a UART line (8N1/8E1/8O1, 1-2 stop bits); start bit falls 2 cycles after the pop.
// Pops only when the FIFO is non-empty in IDLE or on the last stop cycle; the line has no backpressure.
`timescale 1ns/1ps
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fifo_empty_i,
  input  logic [UART_DATA_BITS-1:0] fifo_read_data_i,
  output logic                      fifo_rd_en_o,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic                      tx_done_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST    = (STOP_BITS == 2);
  localparam bit            PARITY_EN    = (PARITY != PARITY_NONE);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_fifo_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_fifo_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_fifo_tx: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t            r_state;
  logic [CW-1:0]             r_baud_cnt;
  logic [2:0]                r_bit_idx;
  logic                      r_stop_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_parity;
  logic                      r_tx;
  logic                      r_rd_en;
  logic                      r_busy;
  logic                      r_tx_done;
  logic                      w_bit_end;
  logic                      w_last_stop;

  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_last_stop = (r_stop_cnt == STOP_LAST);

  assign fifo_rd_en_o = r_rd_en;
  assign tx_o         = r_tx;
  assign busy_o       = r_busy;
  assign tx_done_o    = r_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_rd_en    <= 1'b0;
      r_tx_done  <= 1'b0;
      // Every bit-timed state exits on w_bit_end, so the wrap to 0 doubles as the entry clear.
      r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          if (!fifo_empty_i) begin
            r_state <= ST_FETCH;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_baud_cnt <= '0;
          r_state    <= ST_LOAD;
        end
        ST_LOAD: begin
          r_baud_cnt <= '0;
          r_shift    <= fifo_read_data_i;
          r_parity   <= parity_bit(fifo_read_data_i, PARITY);
          r_tx       <= 1'b0;
          r_state    <= ST_START;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_stop_cnt <= 1'b0;
              if (PARITY_EN) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          // Registered pulse: raise it one cycle early so it lands on the final stop cycle.
          if (w_last_stop && r_baud_cnt == BAUD_PRELAST) r_tx_done <= 1'b1;
          if (w_bit_end) begin
            if (!w_last_stop) begin
              r_stop_cnt <= 1'b1;
            end else if (!fifo_empty_i) begin
              r_rd_en <= 1'b1;
              r_state <= ST_FETCH;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench: three transmitters (8N1, 8E2, 8O1) each fed by an 8-deep FIFO, frames checked against a scoreboard.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

  localparam int NI  = 3;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       fifo_rst_n;
  logic       dut_rst_n [NI];
  logic       wr_en     [NI];
  logic [7:0] wr_dat    [NI];
  logic       rd_en     [NI];
  logic [7:0] rd_dat    [NI];
  logic       empty     [NI];
  logic       full      [NI];
  logic       tx        [NI];
  logic       busy      [NI];
  logic       done      [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    fifo #(.DEPTH(8), .WIDTH(8)) u_fifo (
      .clk      (clk),
      .rst_n    (fifo_rst_n),
      .i_wr_en  (wr_en[g]),
      .i_wr_dat (wr_dat[g]),
      .i_rd_en  (rd_en[g]),
      .o_rd_dat (rd_dat[g]),
      .o_empty  (empty[g]),
      .o_full   (full[g])
    );
    uart_fifo_tx #(
      .CLK_FREQ  (1_000_000),
      .BAUD_RATE (100_000),
      .PARITY    (g),
      .STOP_BITS ((g == 1) ? 2 : 1)
    ) u_dut (
      .clk              (clk),
      .rst_n            (dut_rst_n[g]),
      .fifo_empty_i     (empty[g]),
      .fifo_read_data_i (rd_dat[g]),
      .fifo_rd_en_o     (rd_en[g]),
      .tx_o             (tx[g]),
      .busy_o           (busy[g]),
      .tx_done_o        (done[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Frame bit vectors: bit 0 is the start bit, then data LSB first, parity, stop bit(s).
  typedef struct { int inst; logic [11:0] bits; } exp_t;
  exp_t exp_q[$];

  function automatic int find_exp(input int inst);
    for (int k = 0; k < exp_q.size(); k++) if (exp_q[k].inst == inst) return k;
    return -1;
  endfunction

  function automatic int frame_bits(input int inst);
    return (inst == 0) ? 10 : (inst == 1) ? 12 : 11;
  endfunction

  bit          in_frame [NI];
  int          fcyc     [NI];
  int          herr     [NI];
  int          ndone    [NI];
  int          last_pop [NI];
  int          pops     [NI];
  int          dbl_pop  [NI];
  logic        prev_rd  [NI];
  logic [11:0] cur_exp  [NI];
  logic [11:0] act_bits [NI];
  int          starts0[$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_frame[i] = 0; fcyc[i] = 0; herr[i] = 0; ndone[i] = 0;
      last_pop[i] = 0; pops[i] = 0; dbl_pop[i] = 0; prev_rd[i] = 1'b0;
      cur_exp[i] = '0; act_bits[i] = '0;
    end
  end

  always @(negedge clk) begin
    int k;
    int fl;
    for (int i = 0; i < NI; i++) begin
      fl = frame_bits(i) * CPB;
      if (!dut_rst_n[i]) begin
        in_frame[i] = 0;
        prev_rd[i]  = 1'b0;
      end else begin
        if (rd_en[i]) begin
          pops[i]++;
          last_pop[i] = cyc;
          if (prev_rd[i]) dbl_pop[i]++;
        end
        prev_rd[i] = rd_en[i];
        if (!in_frame[i] && tx[i] === 1'b0) begin
          k = find_exp(i);
          check($sformatf("unexpected_frame_%0d", i), 64'(k < 0), 64'd0);
          in_frame[i] = 1; fcyc[i] = 0; herr[i] = 0; ndone[i] = 0;
          act_bits[i] = '0;
          cur_exp[i]  = (k >= 0) ? exp_q[k].bits : 12'd0;
          check($sformatf("pop_to_start_%0d", i), 64'(cyc - last_pop[i]), 64'd2);
          if (i == 0) starts0.push_back(cyc);
        end
        if (in_frame[i]) begin
          if (tx[i] !== cur_exp[i][fcyc[i] / CPB]) herr[i]++;
          if (busy[i] !== 1'b1) herr[i]++;
          if (done[i]) begin
            ndone[i]++;
            if (fcyc[i] != fl - 1) herr[i]++;
          end
          if (fcyc[i] % CPB == CPB / 2) act_bits[i][fcyc[i] / CPB] = tx[i];
          if (fcyc[i] == fl - 1) begin
            check($sformatf("frame_bits_%0d", i), 64'(act_bits[i]), 64'(cur_exp[i]));
            check($sformatf("frame_timing_%0d", i), 64'(herr[i]), 64'd0);
            check($sformatf("tx_done_count_%0d", i), 64'(ndone[i]), 64'd1);
            k = find_exp(i);
            if (k >= 0) exp_q.delete(k);
            in_frame[i] = 0;
          end
          fcyc[i]++;
        end
      end
    end
  end

  task automatic write(input int inst, input logic [7:0] d, input logic [11:0] bits, input bit expect_it);
    exp_t e;
    @(negedge clk);
    check("fifo_not_full", 64'(full[inst]), 64'd0);
    wr_en[inst]  = 1'b1;
    wr_dat[inst] = d;
    if (expect_it) begin
      e.inst = inst;
      e.bits = bits;
      exp_q.push_back(e);
    end
    @(negedge clk);
    wr_en[inst] = 1'b0;
  endtask

  task automatic drain(input int inst, input string name);
    int t;
    t = 0;
    while ((find_exp(inst) >= 0 || busy[inst] || !empty[inst]) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, 64'(t >= 3000), 64'd0);
    repeat (3) @(negedge clk);
    check({name, "_idle_line"}, 64'(tx[inst]), 64'd1);
    check({name, "_idle_busy"}, 64'(busy[inst]), 64'd0);
  endtask

  typedef struct { int inst; logic [7:0] dat; logic [11:0] bits; } vec_t;
  vec_t vecs [6];

  initial begin
    int p;
    int bad;
    int t;
    int d1;
    int d2;

    vecs[0] = '{1, 8'h07, 12'b11_1_00000111_0};
    vecs[1] = '{2, 8'h07, 12'b0_1_0_00000111_0};
    vecs[2] = '{1, 8'hFF, 12'b11_0_11111111_0};
    vecs[3] = '{2, 8'h00, 12'b0_1_1_00000000_0};
    vecs[4] = '{0, 8'h81, 12'b00_1_10000001_0};
    vecs[5] = '{2, 8'h3C, 12'b0_1_1_00111100_0};

    fifo_rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      dut_rst_n[i] = 1'b0;
      wr_en[i]     = 1'b0;
      wr_dat[i]    = 8'h00;
    end
    repeat (2) @(negedge clk);
    fifo_rst_n = 1'b1;

    // Reset held with a non-empty FIFO, then the single 0xA5 frame on release.
    write(0, 8'hA5, 12'b00_1_10100101_0, 1'b1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || rd_en[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    check("reset_hold_outputs", 64'(bad), 64'd0);
    check("reset_fifo_nonempty", 64'(empty[0]), 64'd0);
    for (int i = 0; i < NI; i++) dut_rst_n[i] = 1'b1;
    drain(0, "single_a5");
    check("single_a5_pops", 64'(pops[0]), 64'd1);

    for (int v = 0; v < 6; v++) begin
      p = pops[vecs[v].inst];
      write(vecs[v].inst, vecs[v].dat, vecs[v].bits, 1'b1);
      drain(vecs[v].inst, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_pops", v), 64'(pops[vecs[v].inst] - p), 64'd1);
    end

    // Burst of three: back-to-back frames, one pop each.
    starts0.delete();
    p = pops[0];
    write(0, 8'h00, 12'b00_1_00000000_0, 1'b1);
    write(0, 8'hFF, 12'b00_1_11111111_0, 1'b1);
    write(0, 8'h3C, 12'b00_1_00111100_0, 1'b1);
    drain(0, "burst");
    check("burst_pops", 64'(pops[0] - p), 64'd3);
    check("burst_frames", 64'(starts0.size()), 64'd3);
    d1 = (starts0.size() >= 2) ? starts0[1] - starts0[0] : -1;
    d2 = (starts0.size() >= 3) ? starts0[2] - starts0[1] : -1;
    check("burst_gap_1", 64'(d1), 64'd102);
    check("burst_gap_2", 64'(d2), 64'd102);
    check("burst_fifo_empty", 64'(empty[0]), 64'd1);
    check("burst_single_cycle_pops", 64'(dbl_pop[0]), 64'd0);

    // Reset mid-DATA (bit 4): popped 0xC3 is lost, 0x96 follows intact.
    p = pops[0];
    write(0, 8'hC3, 12'd0, 1'b0);
    write(0, 8'h96, 12'b00_1_10010110_0, 1'b1);
    t = 0;
    while (!(in_frame[0] && fcyc[0] >= 52) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("mid_reset_wait_timeout", 64'(t >= 2000), 64'd0);
    #2 dut_rst_n[0] = 1'b0;
    #1;
    check("mid_reset_tx_async", 64'(tx[0]), 64'd1);
    check("mid_reset_busy_async", 64'(busy[0]), 64'd0);
    repeat (2) @(negedge clk);
    dut_rst_n[0] = 1'b1;
    drain(0, "after_reset");
    check("after_reset_pops", 64'(pops[0] - p), 64'd2);

    // Long empty stretch, then a single 0x55.
    p = pops[0];
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || rd_en[0] !== 1'b0) bad++;
    end
    check("empty_no_pop", 64'(pops[0] - p), 64'd0);
    check("empty_line_idle", 64'(bad), 64'd0);
    write(0, 8'h55, 12'b00_1_01010101_0, 1'b1);
    drain(0, "late_55");
    check("late_55_pops", 64'(pops[0] - p), 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
